// File: rtl/mult_accumulator.sv
`default_nettype none
// ============================================================================
//  Module   : mult_accumulator
//  Purpose  : Consumer stage behind the 4x4 array multiplier. Accepts one
//             8-bit product per cycle over valid/ready, adds it into a
//             saturating ACC_W-bit accumulator, counts accepted products and
//             keeps a sticky overflow flag. On rd_req the accumulator value is
//             streamed out as two bytes (low, then zero-extended high).
//  Ports    : clk        - clock, all state changes on rising edge
//             rst_n      - synchronous active-low reset
//             prod_in    - unsigned product from the multiplier
//             prod_valid - prod_in valid this cycle
//             prod_ready - block can accept a product this cycle
//             clear      - synchronous clear of acc, count and ovf
//             rd_req     - request a two-byte readout
//             acc_out    - readout byte
//             out_valid  - acc_out carries a readout byte
//             count      - accepted products since clear/reset (saturating)
//             ovf        - sticky saturation flag
//  Revision : 1.0 - initial release
// ============================================================================
module mult_accumulator #(
    parameter int ACC_W = 12,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [7:0]       prod_in,
    input  logic             prod_valid,
    output logic             prod_ready,
    input  logic             clear,
    input  logic             rd_req,
    output logic [7:0]       acc_out,
    output logic             out_valid,
    output logic [CNT_W-1:0] count,
    output logic             ovf
);

    if (ACC_W < 9 || ACC_W > 16) begin : g_acc_w_check
        $error("mult_accumulator: ACC_W must be in 9..16");
    end

    localparam logic [ACC_W-1:0] C_ACC_MAX = {ACC_W{1'b1}};
    localparam logic [CNT_W-1:0] C_CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] C_CNT_ONE = CNT_W'(1);

    typedef enum logic [1:0] {
        ST_ACCUM   = 2'd0,
        ST_SEND_LO = 2'd1,
        ST_SEND_HI = 2'd2
    } state_t;

    state_t             r_state;
    logic [ACC_W-1:0]   r_acc;
    // Only the upper bits of the captured value need holding: the low byte
    // is loaded straight into the output register at the capture edge.
    logic [ACC_W-9:0]   r_shadow_hi;
    logic [CNT_W-1:0]   r_count;
    logic               r_ovf;
    logic [7:0]         r_acc_out;
    logic               r_out_valid;

    logic               w_ready;
    logic               w_accept;
    logic [ACC_W-1:0]   w_acc_base;
    logic [ACC_W:0]     w_sum;
    logic               w_sat;
    logic [ACC_W-1:0]   w_acc_next;
    logic               w_ovf_next;
    logic [CNT_W-1:0]   w_cnt_base;
    logic [CNT_W-1:0]   w_cnt_next;

    // Ready is a function of state and reset only, never of prod_valid.
    assign w_ready  = (r_state == ST_ACCUM) && rst_n;
    assign w_accept = prod_valid && w_ready;

    // Clear is applied before the add, so clear+accept yields acc = prod_in.
    assign w_acc_base = clear ? '0 : r_acc;
    assign w_cnt_base = clear ? '0 : r_count;

    assign w_sum      = {1'b0, w_acc_base} + {{(ACC_W-7){1'b0}}, prod_in};
    assign w_sat      = w_sum[ACC_W];
    assign w_acc_next = !w_accept ? w_acc_base
                      : (w_sat ? C_ACC_MAX : w_sum[ACC_W-1:0]);
    assign w_ovf_next = (clear ? 1'b0 : r_ovf) | (w_accept & w_sat);
    assign w_cnt_next = (w_accept && (w_cnt_base != C_CNT_MAX))
                      ? w_cnt_base + C_CNT_ONE : w_cnt_base;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= ST_ACCUM;
            r_acc       <= '0;
            r_shadow_hi <= '0;
            r_count     <= '0;
            r_ovf       <= 1'b0;
            r_acc_out   <= 8'h00;
            r_out_valid <= 1'b0;
        end else begin
            r_acc   <= w_acc_next;
            r_count <= w_cnt_next;
            r_ovf   <= w_ovf_next;
            case (r_state)
                ST_ACCUM: begin
                    if (rd_req) begin
                        // Snapshot includes any accept/clear at this edge.
                        r_shadow_hi <= w_acc_next[ACC_W-1:8];
                        r_acc_out   <= w_acc_next[7:0];
                        r_out_valid <= 1'b1;
                        r_state     <= ST_SEND_LO;
                    end else begin
                        r_acc_out   <= 8'h00;
                        r_out_valid <= 1'b0;
                    end
                end
                ST_SEND_LO: begin
                    r_acc_out   <= 8'(r_shadow_hi);
                    r_out_valid <= 1'b1;
                    r_state     <= ST_SEND_HI;
                end
                ST_SEND_HI: begin
                    r_acc_out   <= 8'h00;
                    r_out_valid <= 1'b0;
                    r_state     <= ST_ACCUM;
                end
                default: begin
                    r_acc_out   <= 8'h00;
                    r_out_valid <= 1'b0;
                    r_state     <= ST_ACCUM;
                end
            endcase
        end
    end

    assign prod_ready = w_ready;
    assign acc_out    = r_acc_out;
    assign out_valid  = r_out_valid;
    assign count      = r_count;
    assign ovf        = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_mult_accumulator.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mult_accumulator
//  Purpose  : Self-checking bench for mult_accumulator. Directed vector table,
//             hand-written multi-cycle sequences and randomized traffic, all
//             compared against a transaction-level reference model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_mult_accumulator;

    localparam int ACC_W   = 12;
    localparam int CNT_W   = 4;
    localparam int ACC_MAX = (1 << ACC_W) - 1;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic             clk;
    logic             rst_n;
    logic [7:0]       prod_in;
    logic             prod_valid;
    logic             prod_ready;
    logic             clear;
    logic             rd_req;
    logic [7:0]       acc_out;
    logic             out_valid;
    logic [CNT_W-1:0] count;
    logic             ovf;

    mult_accumulator #(.ACC_W(ACC_W), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .prod_in    (prod_in),
        .prod_valid (prod_valid),
        .prod_ready (prod_ready),
        .clear      (clear),
        .rd_req     (rd_req),
        .acc_out    (acc_out),
        .out_valid  (out_valid),
        .count      (count),
        .ovf        (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    // Reference model: plain integers plus a queue of pending readout bytes.
    int         m_acc = 0;
    int         m_cnt = 0;
    int         m_ovf = 0;
    logic [7:0] m_q[$];

    task automatic chk(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic model_edge(input logic r, input logic v, input logic [7:0] p,
                              input logic c, input logic rd);
        bit idle;
        if (!r) begin
            m_acc = 0; m_cnt = 0; m_ovf = 0;
            m_q.delete();
        end else begin
            idle = (m_q.size() == 0);
            if (c) begin
                m_acc = 0; m_cnt = 0; m_ovf = 0;
            end
            if (idle && v) begin
                if (m_acc + int'(p) > ACC_MAX) begin
                    m_acc = ACC_MAX;
                    m_ovf = 1;
                end else begin
                    m_acc = m_acc + int'(p);
                end
                if (m_cnt < CNT_MAX) m_cnt++;
            end
            if (!idle) void'(m_q.pop_front());
            if (idle && rd) begin
                m_q.push_back(8'(m_acc % 256));
                m_q.push_back(8'(m_acc / 256));
            end
        end
    endtask

    // Apply one cycle of inputs, advance model, compare every output.
    task automatic step(input logic r, input logic v, input logic [7:0] p,
                        input logic c, input logic rd);
        rst_n = r; prod_valid = v; prod_in = p; clear = c; rd_req = rd;
        @(posedge clk);
        model_edge(r, v, p, c, rd);
        #1;
        chk("out_valid",  int'(out_valid),  (m_q.size() > 0) ? 1 : 0);
        chk("acc_out",    int'(acc_out),    (m_q.size() > 0) ? int'(m_q[0]) : 0);
        chk("prod_ready", int'(prod_ready), (r && m_q.size() == 0) ? 1 : 0);
        chk("count",      int'(count),      m_cnt);
        chk("ovf",        int'(ovf),        m_ovf);
    endtask

    typedef struct {
        logic       r;
        logic       v;
        logic [7:0] p;
        logic       c;
        logic       rd;
        int         e_out;
        int         e_ov;
        int         e_rdy;
        int         e_cnt;
        int         e_ovf;
    } vec_t;

    vec_t vecs[$];

    initial begin
        rst_n = 1'b0; prod_valid = 1'b0; prod_in = 8'h00; clear = 1'b0; rd_req = 1'b0;

        // inputs: rst_n valid prod clear rd | expected: acc_out out_valid ready count ovf
        vecs.push_back('{1'b0, 1'b0, 8'd0,   1'b0, 1'b0, 'h00, 0, 0, 0, 0}); // reset
        vecs.push_back('{1'b1, 1'b1, 8'd225, 1'b0, 1'b0, 'h00, 0, 1, 1, 0});
        vecs.push_back('{1'b1, 1'b1, 8'd225, 1'b0, 1'b0, 'h00, 0, 1, 2, 0});
        vecs.push_back('{1'b1, 1'b1, 8'd225, 1'b0, 1'b0, 'h00, 0, 1, 3, 0});
        vecs.push_back('{1'b1, 1'b0, 8'd0,   1'b0, 1'b1, 'hA3, 1, 0, 3, 0}); // 675 low
        vecs.push_back('{1'b1, 1'b0, 8'd0,   1'b0, 1'b0, 'h02, 1, 0, 3, 0}); // 675 high
        vecs.push_back('{1'b1, 1'b0, 8'd0,   1'b0, 1'b0, 'h00, 0, 1, 3, 0});
        vecs.push_back('{1'b1, 1'b1, 8'd10,  1'b1, 1'b0, 'h00, 0, 1, 1, 0}); // acc=10
        vecs.push_back('{1'b1, 1'b1, 8'd5,   1'b0, 1'b1, 'h0F, 1, 0, 2, 0}); // accept+rd
        vecs.push_back('{1'b1, 1'b0, 8'd0,   1'b0, 1'b0, 'h00, 1, 0, 2, 0});
        vecs.push_back('{1'b1, 1'b0, 8'd0,   1'b0, 1'b0, 'h00, 0, 1, 2, 0});
        vecs.push_back('{1'b1, 1'b0, 8'd0,   1'b0, 1'b1, 'h0F, 1, 0, 2, 0}); // into SEND_LO
        vecs.push_back('{1'b0, 1'b0, 8'd0,   1'b0, 1'b0, 'h00, 0, 0, 0, 0}); // reset mid-readout
        vecs.push_back('{1'b0, 1'b0, 8'd0,   1'b0, 1'b0, 'h00, 0, 0, 0, 0});
        vecs.push_back('{1'b1, 1'b0, 8'd0,   1'b0, 1'b0, 'h00, 0, 1, 0, 0}); // released

        foreach (vecs[i]) begin
            step(vecs[i].r, vecs[i].v, vecs[i].p, vecs[i].c, vecs[i].rd);
            chk($sformatf("vec%0d.acc_out", i),   int'(acc_out),    vecs[i].e_out);
            chk($sformatf("vec%0d.out_valid", i), int'(out_valid),  vecs[i].e_ov);
            chk($sformatf("vec%0d.prod_ready", i),int'(prod_ready), vecs[i].e_rdy);
            chk($sformatf("vec%0d.count", i),     int'(count),      vecs[i].e_cnt);
            chk($sformatf("vec%0d.ovf", i),       int'(ovf),        vecs[i].e_ovf);
        end

        // Saturation: 18 x 225 = 4050 fits, 19th saturates to 4095.
        step(1'b1, 1'b0, 8'd0, 1'b1, 1'b0);
        for (int i = 0; i < 18; i++) step(1'b1, 1'b1, 8'd225, 1'b0, 1'b0);
        chk("sat.ovf_before", int'(ovf), 0);
        step(1'b1, 1'b1, 8'd225, 1'b0, 1'b0);
        chk("sat.ovf_after", int'(ovf), 1);
        chk("sat.count_sat", int'(count), 15);
        step(1'b1, 1'b0, 8'd0, 1'b0, 1'b1);
        chk("sat.lo", int'(acc_out), 'hFF);
        step(1'b1, 1'b0, 8'd0, 1'b0, 1'b0);
        chk("sat.hi", int'(acc_out), 'h0F);
        step(1'b1, 1'b0, 8'd0, 1'b0, 1'b0);
        chk("sat.ovf_sticky", int'(ovf), 1);

        // Clear together with accept.
        step(1'b1, 1'b1, 8'd7, 1'b1, 1'b0);
        chk("clracc.count", int'(count), 1);
        chk("clracc.ovf", int'(ovf), 0);

        // Backpressure during readout, repeated rd_req ignored.
        step(1'b1, 1'b0, 8'd0, 1'b0, 1'b1);
        chk("bp.lo", int'(acc_out), 7);
        chk("bp.ready_lo", int'(prod_ready), 0);
        step(1'b1, 1'b1, 8'd9, 1'b0, 1'b1);
        chk("bp.ready_hi", int'(prod_ready), 0);
        chk("bp.count_hold", int'(count), 1);
        step(1'b1, 1'b1, 8'd9, 1'b0, 1'b1);
        chk("bp.ready_back", int'(prod_ready), 1);
        chk("bp.no_requeue", int'(out_valid), 0);
        chk("bp.count_hold2", int'(count), 1);
        step(1'b1, 1'b1, 8'd9, 1'b0, 1'b0);
        chk("bp.accepted", int'(count), 2);
        step(1'b1, 1'b0, 8'd0, 1'b0, 1'b1);
        chk("bp.sum_lo", int'(acc_out), 16);
        step(1'b1, 1'b0, 8'd0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 8'd0, 1'b0, 1'b0);

        // Randomized traffic against the model.
        for (int i = 0; i < 400; i++) begin
            logic       r, v, c, rd;
            logic [7:0] p;
            r  = ($urandom_range(0, 99) != 0);
            v  = ($urandom_range(0, 9) < 7);
            c  = ($urandom_range(0, 49) == 0);
            rd = ($urandom_range(0, 9) < 2);
            p  = 8'($urandom_range(0, 15) * $urandom_range(0, 15));
            step(r, v, p, c, rd);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mult_accumulator.md
# mult_accumulator

Sequential consumer stage placed directly downstream of the 4x4 array multiplier. Each cycle it can accept one 8-bit product over a valid/ready handshake and add it into a saturating accumulator. It also tracks the number of products accepted and a sticky overflow flag. On request, it streams the accumulated value out as two bytes over an 8-bit bus, so the result fits the 8-bit dedicated output pins.

## Interface
Parameters:
- ACC_W, 12, accumulator width in bits; legal range 9..16
- CNT_W, 4, width of the accepted-product counter

Ports:
- clk  in  1  clock; all state changes on rising edge
- rst_n  in  1  reset, synchronous, active-low
- prod_in  in  8  unsigned product from the multiplier
- prod_valid  in  1  prod_in is valid this cycle
- prod_ready  out  1  block can accept a product this cycle
- clear  in  1  synchronous clear of the accumulator, counter and overflow flag
- rd_req  in  1  request a two-byte readout of the accumulator
- acc_out  out  8  readout byte
- out_valid  out  1  acc_out carries a readout byte this cycle
- count  out  CNT_W  number of products accepted since the last clear or reset (saturating)
- ovf  out  1  sticky saturation flag

## Operation
- States: ACCUM, SEND_LO, SEND_HI. Reset state is ACCUM.
- prod_ready = 1 only in ACCUM, and only while rst_n = 1.
- Accept: a product is accepted when prod_valid and prod_ready are both 1 at a rising edge.
- Accumulate: on accept, compute sum = acc + prod_in at ACC_W+1 bits.
  - If sum > 2^ACC_W−1: acc <= 2^ACC_W−1 and ovf <= 1.
  - Otherwise: acc <= sum.
- Counter: on accept, count increments and saturates at 2^CNT_W−1; it does not wrap.
- ovf stays at 1 until clear or reset.
- Clear: clear = 1 at an edge forces acc, count and ovf to 0. It applies in every state.
- Clear and accept in the same edge: clear is applied first, then the add. Result: acc <= prod_in, count <= 1, ovf <= 0.
- Readout request: rd_req in ACCUM loads shadow <= next value of acc (including any product accepted, or clear applied, at the same edge), then state <= SEND_LO.
- SEND_LO: acc_out = shadow[7:0], out_valid = 1; next state SEND_HI.
- SEND_HI: acc_out = shadow[ACC_W−1:8] zero-extended to 8 bits, out_valid = 1; next state ACCUM.
- In ACCUM: acc_out = 0, out_valid = 0.
- rd_req in SEND_LO or SEND_HI is ignored; it is not queued.
- prod_valid in SEND_LO or SEND_HI is not accepted; acc and count are unchanged.
- A clear during SEND_LO/SEND_HI clears acc, but the in-flight readout still comes from shadow.
- Reset values (rst_n = 0 at an edge): state ACCUM, acc = 0, shadow = 0, count = 0, ovf = 0, acc_out = 0, out_valid = 0. prod_ready is 0 while rst_n = 0.
- Reset mid-readout aborts the readout; out_valid is 0 from the next cycle.

## Timing
- acc, count and ovf update at the edge of acceptance and are visible in the following cycle.
- Product throughput: one product per cycle in ACCUM.
- Readout latency, with rd_req high at edge N:
  - low byte valid during cycle N+1
  - high byte valid during cycle N+2
  - prod_ready back to 1 and out_valid 0 during cycle N+3
- out_valid is high for exactly two consecutive cycles per readout.
- acc_out and out_valid are decoded from state and shadow registers only; there is no combinational path from any input.
- prod_ready depends only on state and rst_n; it has no dependence on prod_valid.

## Test plan
- Reset: rst_n held low 2 cycles during SEND_LO -> acc_out = 0, out_valid = 0, count = 0, ovf = 0; prod_ready = 1 on the first cycle after release.
- Accumulate: three accepts of 225 (15×15), then rd_req -> bytes 0xA3 then 0x02 (675); count = 3, ovf = 0.
- Saturation, ACC_W = 12: nineteen accepts of 225 -> acc = 4095 and ovf = 1 after the 19th; readout 0xFF then 0x0F; ovf stays 1 until clear.
- Simultaneous accept and readout: acc = 10, prod_in = 5 with rd_req at the same edge -> readout 0x0F then 0x00; count increments by 1.
- Clear with accept: acc = 300, ovf = 1, clear together with prod_in = 7 -> acc = 7, count = 1, ovf = 0.
- Backpressure: prod_valid held high with prod_in = 9 through SEND_LO/SEND_HI -> prod_ready = 0 for those 2 cycles and acc unchanged; the product is accepted on the first ACCUM cycle; a repeated rd_req during SEND is ignored.
